// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, derived raster totals and
// sync windows, the screen-state encoding used by the pixel path, and a
// window-decode helper for the raster counters.
package vga_pkg;

  // Coordinate counter width; raster totals must fit in 10 bits.
  localparam int unsigned CNT_W = 10;

  // Default 640x480@60 timing, in pixel ticks and lines.
  localparam int unsigned CLK_DIV_DEF  = 4;
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  // Derived totals and inclusive sync windows for the default raster.
  localparam int unsigned H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
  localparam int unsigned H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
  localparam int unsigned V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

  // Screen selected by the pixel-generation path.
  typedef enum logic [1:0] {
    MENU = 2'd0,
    GAME = 2'd1,
    OVER = 2'd2
  } screen_state_e;

  // Unsigned inclusive window test on a raster coordinate.
  function automatic logic in_window(input logic [CNT_W-1:0] x,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate divider: counts 0..CLK_DIV-1 and emits a one-clk tick on the clk
// where the count is at its last value. The fire condition is also exposed
// combinationally so the raster counters can advance on the same edge that
// raises the registered tick.
module pixel_tick_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick,
  output logic o_fire_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic             r_tick;

  // Fire on the last divider count; constantly true when CLK_DIV is 1.
  assign o_fire_c = (r_div_cnt == DIV_LAST);

  // Divider counter and registered tick, both restarting from zero on reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_cnt <= '0;
      r_tick    <= 1'b0;
    end else begin
      r_tick    <= o_fire_c;
      r_div_cnt <= o_fire_c ? '0 : (r_div_cnt + DIV_W'(1));
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: pixel-rate tick, h/v coordinates, syncs and the
// active-video flag, all registered. Counters and sync decode advance together
// on the divider fire, so every output describes the new position.
// Build option VGA_SYNC_DELAY_EN: hsync/vsync/valid pass through a SYNC_DELAY
// stage line clocked by the pixel tick, to line up with a block-RAM pixel path.
// Coordinates and frame_start are never delayed.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pixel_tick,
  output logic       frame_start,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync,
  output logic       vsync,
  output logic       valid
);

`ifdef VGA_SYNC_DELAY_EN
  localparam bit LP_DLY_EN = 1'b1;
`else
  localparam bit LP_DLY_EN = 1'b0;
`endif

  // Effective sync/valid delay in pixel ticks; zero when the option is off.
  localparam int unsigned LP_DLY = LP_DLY_EN ? SYNC_DELAY : 0;

  localparam int unsigned LP_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned LP_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] LP_H_LAST   = CNT_W'(LP_H_TOTAL - 1);
  localparam logic [CNT_W-1:0] LP_V_LAST   = CNT_W'(LP_V_TOTAL - 1);
  localparam logic [CNT_W-1:0] LP_H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] LP_V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] LP_HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] LP_HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] LP_VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] LP_VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  localparam logic LP_SYNC_ON  = SYNC_POL;
  localparam logic LP_SYNC_OFF = ~SYNC_POL;

  logic             w_tick;
  logic             w_fire_c;

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             r_frame_start;
  logic             r_hsync;
  logic             r_vsync;
  logic             r_valid;

  logic [CNT_W-1:0] w_h_next;
  logic [CNT_W-1:0] w_v_next;
  logic             w_wrap;
  logic             w_hsync_next;
  logic             w_vsync_next;
  logic             w_valid_next;

  pixel_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_gen (
    .i_clk    (clk),
    .i_rst    (rst),
    .o_tick   (w_tick),
    .o_fire_c (w_fire_c)
  );

  // Next raster position and the sync/valid levels that belong to it.
  always_comb begin
    w_h_next = r_h_cnt + CNT_W'(1);
    w_v_next = r_v_cnt;
    w_wrap   = 1'b0;
    if (r_h_cnt == LP_H_LAST) begin
      w_h_next = '0;
      if (r_v_cnt == LP_V_LAST) begin
        w_v_next = '0;
        w_wrap   = 1'b1;
      end else begin
        w_v_next = r_v_cnt + CNT_W'(1);
      end
    end
    w_hsync_next = in_window(w_h_next, LP_HS_START, LP_HS_END) ? LP_SYNC_ON : LP_SYNC_OFF;
    w_vsync_next = in_window(w_v_next, LP_VS_START, LP_VS_END) ? LP_SYNC_ON : LP_SYNC_OFF;
    w_valid_next = (w_h_next < LP_H_ACT) && (w_v_next < LP_V_ACT);
  end

  // Raster counters and undelayed sync/valid; reset parks on the last blank pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt       <= LP_H_LAST;
      r_v_cnt       <= LP_V_LAST;
      r_frame_start <= 1'b0;
      r_hsync       <= LP_SYNC_OFF;
      r_vsync       <= LP_SYNC_OFF;
      r_valid       <= 1'b0;
    end else begin
      r_frame_start <= w_fire_c && w_wrap;
      if (w_fire_c) begin
        r_h_cnt <= w_h_next;
        r_v_cnt <= w_v_next;
        r_hsync <= w_hsync_next;
        r_vsync <= w_vsync_next;
        r_valid <= w_valid_next;
      end
    end
  end

  generate
    if (LP_DLY == 0) begin : g_no_dly
      assign hsync = r_hsync;
      assign vsync = r_vsync;
      assign valid = r_valid;
    end else begin : g_dly
      logic [LP_DLY-1:0] r_hs_dly;
      logic [LP_DLY-1:0] r_vs_dly;
      logic [LP_DLY-1:0] r_vld_dly;

      // Tick-clocked delay line; stage 0 captures the level of the position being left.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_hs_dly  <= {LP_DLY{LP_SYNC_OFF}};
          r_vs_dly  <= {LP_DLY{LP_SYNC_OFF}};
          r_vld_dly <= '0;
        end else if (w_fire_c) begin
          r_hs_dly[0]  <= r_hsync;
          r_vs_dly[0]  <= r_vsync;
          r_vld_dly[0] <= r_valid;
          for (int i = 1; i < int'(LP_DLY); i++) begin
            r_hs_dly[i]  <= r_hs_dly[i-1];
            r_vs_dly[i]  <= r_vs_dly[i-1];
            r_vld_dly[i] <= r_vld_dly[i-1];
          end
        end
      end

      assign hsync = r_hs_dly[LP_DLY-1];
      assign vsync = r_vs_dly[LP_DLY-1];
      assign valid = r_vld_dly[LP_DLY-1];
    end
  endgenerate

  assign pixel_tick  = w_tick;
  assign frame_start = r_frame_start;
  assign h_cnt       = r_h_cnt;
  assign v_cnt       = r_v_cnt;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: full-width 800-tick lines with a shortened
// 19-line frame so a whole frame fits the cycle budget. A closed-form raster
// model (position = ticks since reset release, modulo frame size) is compared
// with the DUT every clk; directed checks pin the model with literal values.
module tb_vga_timing_ctrl;

  localparam int CLK_DIV = 4;
  localparam int HA = 640, HFP = 16, HS = 96, HBP = 48;
  localparam int VA = 12,  VFP = 2,  VS = 2,  VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int WAIT_LIMIT = FRAME * CLK_DIV + 100;

`ifdef VGA_SYNC_DELAY_EN
  localparam int D = 2;
`else
  localparam int D = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pixel_tick, frame_start, hsync, vsync, valid;
  logic [9:0] h_cnt, v_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  vga_timing_ctrl #(
    .CLK_DIV(CLK_DIV), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0), .SYNC_DELAY(2)
  ) dut (
    .clk(clk), .rst(rst), .pixel_tick(pixel_tick), .frame_start(frame_start),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .hsync(hsync), .vsync(vsync), .valid(valid)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural model and per-clk compare ----------------
  int  k = 0;
  bit  seen_rst = 0;
  bit  rst_s;
  bit  have_fs = 0;
  int  since = 0, acc = 0;
  int  meas_period = 0, meas_valid = 0, meas_n = 0;

  function automatic int pos_after(input int ticks);
    return (FRAME - 1 + ticks) % FRAME;
  endfunction

  always @(posedge clk) begin
    int n, p, q, qh, qv;
    int e_tick, e_fs, e_vld, e_hs, e_vs;
    rst_s = rst;
    if (rst_s) begin
      k = 0;
      seen_rst = 1;
      have_fs = 0;
    end else begin
      k++;
    end
    #1;
    if (seen_rst) begin
      n      = k / CLK_DIV;
      e_tick = (k > 0 && (k % CLK_DIV) == 0) ? 1 : 0;
      p      = pos_after(n);
      e_fs   = (e_tick == 1 && p == 0) ? 1 : 0;
      if (n >= D) begin
        q  = pos_after(n - D);
        qh = q % HT;
        qv = q / HT;
        e_vld = (qh < HA && qv < VA) ? 1 : 0;
        e_hs  = (qh >= HA + HFP && qh < HA + HFP + HS) ? 0 : 1;
        e_vs  = (qv >= VA + VFP && qv < VA + VFP + VS) ? 0 : 1;
      end else begin
        e_vld = 0; e_hs = 1; e_vs = 1;
      end
      check("m_tick",  int'(pixel_tick),  e_tick);
      check("m_fs",    int'(frame_start), e_fs);
      check("m_h",     int'(h_cnt),       p % HT);
      check("m_v",     int'(v_cnt),       p / HT);
      check("m_valid", int'(valid),       e_vld);
      check("m_hsync", int'(hsync),       e_hs);
      check("m_vsync", int'(vsync),       e_vs);
      if (!rst_s) begin
        since++;
        if (frame_start) begin
          if (have_fs) begin
            meas_period = since;
            meas_valid  = acc;
            meas_n++;
          end
          have_fs = 1;
          since = 0;
          acc = 0;
        end
        if (pixel_tick && valid) acc++;
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_pos(input int h, input int v, input string name);
    int  cnt = 0;
    bit  hit = 0;
    while (!hit && cnt < WAIT_LIMIT) begin
      @(posedge clk); #1;
      cnt++;
      if (pixel_tick && int'(h_cnt) == h && int'(v_cnt) == v) hit = 1;
    end
    check(name, int'(hit), 1);
  endtask

  task automatic next_tick(input string name);
    int cnt = 0;
    bit hit = 0;
    while (!hit && cnt < 2 * CLK_DIV + 2) begin
      @(posedge clk); #1;
      cnt++;
      if (pixel_tick) hit = 1;
    end
    check(name, int'(hit), 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t_fall0, low_ticks, guard, n_rst, run_len, hold_len;

    // Reset held for 3 clks.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_h",     int'(h_cnt), 799);
      check("rst_v",     int'(v_cnt), 18);
      check("rst_valid", int'(valid), 0);
      check("rst_hsync", int'(hsync), 1);
      check("rst_vsync", int'(vsync), 1);
      check("rst_tick",  int'(pixel_tick), 0);
    end
    @(negedge clk) rst = 1'b0;

    // First tick on the 4th clk after release.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("pre_tick", int'(pixel_tick), 0);
      check("pre_h",    int'(h_cnt), 799);
    end
    @(posedge clk); #1;
    check("first_tick",  int'(pixel_tick), 1);
    check("first_h",     int'(h_cnt), 0);
    check("first_v",     int'(v_cnt), 0);
    check("first_fs",    int'(frame_start), 1);
    check("first_valid", int'(valid), (D == 0) ? 1 : 0);
    @(posedge clk); #1;
    check("fs_one_clk",   int'(frame_start), 0);
    check("tick_one_clk", int'(pixel_tick), 0);

    // Active-to-blank edge within line 10.
    wait_pos(639, 10, "reach_639_10");
    next_tick("tick_640");
    check("h_640",     int'(h_cnt), 640);
    check("valid_640", int'(valid), (D == 0) ? 0 : 1);

    // hsync pulse: fall, width, rise.
    wait_pos(655, 10, "reach_655_10");
    check("hs_before", int'(hsync), 1);
    guard = 0;
    while (hsync && guard < 10) begin next_tick("hs_fall_wait"); guard++; end
    check("hs_fall_h", int'(h_cnt), 656 + D);
    t_fall0 = cyc;
    low_ticks = 1;
    guard = 0;
    next_tick("hs_low_step");
    while (!hsync && guard < 200) begin low_ticks++; guard++; next_tick("hs_low_step"); end
    check("hs_low_ticks", low_ticks, 96);
    check("hs_rise_h",    int'(h_cnt), 752 + D);

    // Line wrap 799 -> 0 with v increment.
    wait_pos(799, 10, "reach_799_10");
    next_tick("tick_wrap");
    check("wrap_h",     int'(h_cnt), 0);
    check("wrap_v",     int'(v_cnt), 11);
    check("wrap_valid", int'(valid), (D == 0) ? 1 : 0);

    // hsync period.
    guard = 0;
    while (hsync && guard < 1000) begin next_tick("hs_fall2_wait"); guard++; end
    check("hs_period", cyc - t_fall0, 3200);

    // vsync window.
    wait_pos(799, 13, "reach_799_13");
    check("vs_before", int'(vsync), 1);
    next_tick("tick_v14");
    check("vs_v14", int'(vsync), (D == 0) ? 0 : 1);
    guard = 0;
    while (vsync && guard < 10) begin next_tick("vs_fall_wait"); guard++; end
    low_ticks = 1;
    guard = 0;
    next_tick("vs_low_step");
    while (!vsync && guard < 4000) begin low_ticks++; guard++; next_tick("vs_low_step"); end
    check("vs_low_ticks", low_ticks, 1600);
    check("vs_rise_v",    int'(v_cnt), 16);
    check("vs_rise_h",    int'(h_cnt), D);

    // Whole-frame statistics.
    guard = 0;
    while (meas_n == 0 && guard < WAIT_LIMIT) begin @(posedge clk); #1; guard++; end
    check("frame_seen",   meas_n, 1);
    check("frame_period", meas_period, FRAME * CLK_DIV);
    check("frame_period_lit", meas_period, 60800);
    check("frame_valid",  meas_valid, 7680);

    // Reset mid-frame two clks after a tick.
    wait_pos(300, 1, "reach_300_1");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("mid_h",     int'(h_cnt), 799);
    check("mid_v",     int'(v_cnt), 18);
    check("mid_tick",  int'(pixel_tick), 0);
    check("mid_hsync", int'(hsync), 1);
    check("mid_vsync", int'(vsync), 1);
    check("mid_valid", int'(valid), 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("mid_pre_tick", int'(pixel_tick), 0);
    end
    @(posedge clk); #1;
    check("mid_first_tick", int'(pixel_tick), 1);
    check("mid_first_h",    int'(h_cnt), 0);
    check("mid_first_fs",   int'(frame_start), 1);

    // Random run lengths and reset pulses; the model checks every clk.
    n_rst = 8;
    for (int i = 0; i < n_rst; i++) begin
      run_len  = $urandom_range(1500, 5);
      hold_len = $urandom_range(4, 1);
      repeat (run_len) @(negedge clk);
      rst = 1'b1;
      repeat (hold_len) @(negedge clk);
      rst = 1'b0;
    end
    repeat (500) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
